pmem_responder: RTL

//  Physical-memory responder: the memory-side end of the cache<->pmem interface.

---
 rtl/pmem_responder.sv | 110 +++++++++++
 1 files changed

// File: rtl/pmem_responder.sv
// Memory-side end of the cache<->pmem interface: a line-addressed backing store
// that answers each read/write request with a one-cycle pmem_resp after a fixed latency.
module pmem_responder #(
  parameter int IDX_W     = 5,
  parameter int READ_LAT  = 4,
  parameter int WRITE_LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         proto_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count,
  output logic         state_dbg
);

  // Handshake: pmem_read/pmem_write are levels held by the requester until the
  // pmem_resp pulse; they are sampled only in IDLE, and the requester must drop or
  // change them in the cycle after pmem_resp, where a visible request is a new one.

  localparam int DEPTH   = 2 ** IDX_W;
  localparam int MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int CNT_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [CNT_W-1:0] RD_CNT0 = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT0 = CNT_W'(WRITE_LAT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_rd;
  logic [IDX_W-1:0]   idx;
  logic [255:0]       wdata_q;
  logic [255:0]       store [DEPTH];

  logic               accept;
  logic [IDX_W-1:0]   req_idx;
  logic               rd_load;
  logic [IDX_W-1:0]   rd_load_idx;
  logic               unused_addr;

  assign accept      = (state == IDLE) && (pmem_read || pmem_write);
  assign req_idx     = pmem_address[IDX_W+4:5];
  assign unused_addr = ^{pmem_address[31:IDX_W+5], pmem_address[4:0]};

  // rdata is loaded at the edge that enters the resp cycle so it is valid there;
  // with a 1-cycle read latency that edge is the accept edge itself.
  assign rd_load     = (accept && pmem_read && (READ_LAT == 1)) ||
                       ((state == BUSY) && op_rd && (cnt == CNT_W'(1)));
  assign rd_load_idx = accept ? req_idx : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pmem_read || pmem_write) state_nxt = BUSY;
      BUSY:    if (cnt == '0)               state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pmem_resp = (state == BUSY) && (cnt == '0);
    state_dbg = state;
  end

  // Read wins when both requests are raised together; no write is performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      op_rd      <= 1'b0;
      idx        <= '0;
      wdata_q    <= '0;
      pmem_rdata <= '0;
      proto_err  <= 1'b0;
      rd_count   <= '0;
      wr_count   <= '0;
      for (int i = 0; i < DEPTH; i++) store[i] <= '0;
    end else begin
      if (accept) begin
        op_rd   <= pmem_read;
        idx     <= req_idx;
        wdata_q <= pmem_wdata;
        cnt     <= pmem_read ? RD_CNT0 : WR_CNT0;
        if (pmem_read && pmem_write) proto_err <= 1'b1;
      end else if ((state == BUSY) && (cnt != '0)) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (rd_load) pmem_rdata <= store[rd_load_idx];
      if (pmem_resp) begin
        if (op_rd) begin
          rd_count <= rd_count + 16'd1;
        end else begin
          wr_count   <= wr_count + 16'd1;
          store[idx] <= wdata_q;
        end
      end
    end
  end

endmodule
